// File: rtl/vector100_deser.sv
// vector100_deser: valid/ready serial-to-parallel loader, WIDTH bits per word, held until downstream accepts.
// Define VECTOR100_DESER_LSB_FIRST_EN to put the first serial bit in out_data[0] instead of out_data[WIDTH-1].
module vector100_deser #(
    parameter int WIDTH = 100,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_clear,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] fill_cnt
);
    typedef enum logic {FILL, HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt, shifted;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last;

`ifdef VECTOR100_DESER_LSB_FIRST_EN
    assign shifted = {in_bit, sr[WIDTH-1:1]};
`else
    assign shifted = {sr[WIDTH-2:0], in_bit};
`endif

    assign last      = cnt == CNT_W'(WIDTH - 1);
    assign in_ready  = state == FILL;
    assign out_valid = state == HOLD;
    assign out_data  = sr;
    assign fill_cnt  = cnt;

    // Clear outranks both the bit accept and the downstream handoff.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        if (in_clear) begin
            state_nxt = FILL;
            cnt_nxt   = '0;
            sr_nxt    = '0;
        end else if (state == FILL && in_valid) begin
            sr_nxt    = shifted;
            cnt_nxt   = last ? '0 : cnt + CNT_W'(1);
            state_nxt = last ? HOLD : FILL;
        end else if (state == HOLD && out_ready) begin
            state_nxt = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= FILL;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
        end
    end
endmodule

// File: tb/tb_vector100_deser.sv
// tb_vector100_deser: directed self-checking bench for vector100_deser (either bit-order build).
module tb_vector100_deser;
    logic        clk = 0;
    logic        resetn, in_bit, in_valid, in_clear, out_ready;
    logic        in_ready, out_valid;
    logic [99:0] out_data;
    logic [6:0]  fill_cnt;
    int          errs = 0;
    int          checks = 0;

    vector100_deser dut (
        .clk(clk), .resetn(resetn), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .in_clear(in_clear), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_word(input logic b);
        in_valid = 1;
        in_bit   = b;
        repeat (100) step();
        in_valid = 0;
    endtask

    task automatic test_reset;
        resetn = 0; in_bit = 0; in_valid = 0; in_clear = 0; out_ready = 0;
        step();
        step();
        resetn = 1;
        checks++; if (out_data !== 100'd0) begin errs++; $display("FAIL reset_data: got %h expected 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (fill_cnt !== 7'd0) begin errs++; $display("FAIL reset_fill_cnt: got %0d expected 0", fill_cnt); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_word;
        logic [99:0] exp;
`ifdef VECTOR100_DESER_LSB_FIRST_EN
        exp = 100'd1;
`else
        exp = 100'd1 << 99;
`endif
        in_valid = 1;
        for (int i = 0; i < 99; i++) begin
            in_bit = (i == 0);
            step();
        end
        checks++; if (fill_cnt !== 7'd99 || out_valid !== 1'b0) begin errs++; $display("FAIL single_99: got cnt=%0d ov=%b expected cnt=99 ov=0", fill_cnt, out_valid); end
        in_bit = 0;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== exp) begin errs++; $display("FAIL single_data: got %h expected %h", out_data, exp); end
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL single_in_ready: got %b expected 0", in_ready); end
        checks++; if (fill_cnt !== 7'd0) begin errs++; $display("FAIL single_cnt_wrap: got %0d expected 0", fill_cnt); end
        out_ready = 1;
        step();
        out_ready = 0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL single_handoff: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid); end
        checks++; if (out_data !== exp) begin errs++; $display("FAIL single_data_kept: got %h expected %h", out_data, exp); end
    endtask

    task automatic test_backpressure;
        logic [99:0] exp;
`ifdef VECTOR100_DESER_LSB_FIRST_EN
        exp = {50{2'b10}};
`else
        exp = {50{2'b01}};
`endif
        in_valid = 1;
        for (int i = 0; i < 100; i++) begin
            in_bit = i[0];
            step();
        end
        checks++; if (out_data !== exp || out_valid !== 1'b1) begin errs++; $display("FAIL bp_word: got %h ov=%b expected %h ov=1", out_data, out_valid, exp); end
        for (int i = 0; i < 20; i++) begin
            in_bit = ~in_bit;
            step();
            checks++;
            if (out_data !== exp || fill_cnt !== 7'd0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold[%0d]: got data=%h cnt=%0d ov=%b ir=%b expected data=%h cnt=0 ov=1 ir=0", i, out_data, fill_cnt, out_valid, in_ready, exp);
            end
        end
        in_valid = 0;
        out_ready = 1;
        step();
        out_ready = 0;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release: got %b expected 1", in_ready); end
    endtask

    task automatic test_gapped;
        int acc;
        in_bit = 1;
        for (int i = 0; i < 200; i++) begin
            in_valid = (i % 2 == 0);
            step();
            acc = i / 2 + 1;
            checks++;
            if (fill_cnt !== 7'(acc % 100) || out_valid !== (acc == 100)) begin
                errs++;
                $display("FAIL gap[%0d]: got cnt=%0d ov=%b expected cnt=%0d ov=%b", i, fill_cnt, out_valid, acc % 100, acc == 100);
            end
        end
        in_valid = 0;
        checks++; if (out_data !== {100{1'b1}}) begin errs++; $display("FAIL gap_data: got %h expected all ones", out_data); end
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_flush;
        logic [99:0] exp;
`ifdef VECTOR100_DESER_LSB_FIRST_EN
        exp = 100'd1 << 99;
`else
        exp = 100'd1;
`endif
        in_valid = 1;
        in_bit   = 1;
        repeat (37) step();
        checks++; if (fill_cnt !== 7'd37) begin errs++; $display("FAIL flush_pre_cnt: got %0d expected 37", fill_cnt); end
        in_clear = 1;
        step();
        in_clear = 0;
        checks++; if (fill_cnt !== 7'd0 || out_data !== 100'd0 || in_ready !== 1'b1) begin errs++; $display("FAIL flush_clear: got cnt=%0d data=%h ir=%b expected cnt=0 data=0 ir=1", fill_cnt, out_data, in_ready); end
        step();
        in_valid = 0;
        checks++; if (fill_cnt !== 7'd1 || out_data !== exp) begin errs++; $display("FAIL flush_next_bit: got cnt=%0d data=%h expected cnt=1 data=%h", fill_cnt, out_data, exp); end
        fill_word(1'b1);
        in_clear  = 1;
        out_ready = 1;
        step();
        in_clear  = 0;
        out_ready = 0;
        checks++; if (out_valid !== 1'b0 || out_data !== 100'd0 || fill_cnt !== 7'd0) begin errs++; $display("FAIL flush_in_hold: got ov=%b data=%h cnt=%0d expected ov=0 data=0 cnt=0", out_valid, out_data, fill_cnt); end
    endtask

    task automatic test_reset_hold;
        fill_word(1'b1);
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rst_hold_pre: got %b expected 1", out_valid); end
        resetn = 0;
        step();
        resetn = 1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL rst_hold: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready); end
        checks++; if (out_data !== 100'd0 || fill_cnt !== 7'd0) begin errs++; $display("FAIL rst_hold_state: got data=%h cnt=%0d expected 0 0", out_data, fill_cnt); end
        out_ready = 1;
        step();
        out_ready = 0;
        checks++; if (in_ready !== 1'b1 || fill_cnt !== 7'd0) begin errs++; $display("FAIL out_ready_in_fill: got ir=%b cnt=%0d expected ir=1 cnt=0", in_ready, fill_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_gapped();
        test_flush();
        test_reset_hold();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
